// File: rtl/sd_cmd_ctrl_if.sv
// Bundle of request, response and CMD-pad signals shared between the
// SD command sequencer and whoever drives it (card-init FSM plus pad/strobe source).
interface sd_cmd_ctrl_if;
    logic        bit_en;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  resp_type;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;
    logic [47:0] resp;
    logic        crc_err;
    logic        timeout;

    modport master (
        output bit_en, start, cmd_index, cmd_arg, resp_type, cmd_in,
        input  cmd_out, cmd_oe, busy, done, resp, crc_err, timeout
    );

    modport slave (
        input  bit_en, start, cmd_index, cmd_arg, resp_type, cmd_in,
        output cmd_out, cmd_oe, busy, done, resp, crc_err, timeout
    );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line transaction sequencer: shifts out a 48-bit command frame with CRC7,
// then optionally waits for and captures a 48-bit response, checking its CRC7.
module sd_cmd_ctrl #(
    parameter int TIMEOUT_BITS = 64,
    parameter int NRC_BITS     = 8
) (
    input logic          clk,
    input logic          rst,
    sd_cmd_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_NRC,
        S_DONE
    } state_t;

    localparam logic [15:0] FRAME_LAST = 16'd47;
    localparam logic [15:0] CRC_BITS   = 16'd40;
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_BITS - 1);
    localparam logic [15:0] NRC_LAST   = 16'(NRC_BITS - 1);

    state_t      state;
    state_t      state_next;
    logic [39:0] shift_reg;
    logic [1:0]  rtype;
    logic [6:0]  crc;
    logic [15:0] cnt;
    logic        cmd_out_r;
    logic        cmd_oe_r;
    logic [47:0] resp_r;
    logic        crc_err_r;
    logic        timeout_r;
    logic        active;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.bit_en && cnt == FRAME_LAST) begin
                    state_next = (rtype == 2'd0) ? S_NRC : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.bit_en) begin
                    if (!bus.cmd_in) begin
                        state_next = S_RECV;
                    end else if (cnt == TO_LAST) begin
                        state_next = S_NRC;
                    end
                end
            end
            S_RECV: begin
                if (bus.bit_en && cnt == FRAME_LAST) begin
                    state_next = S_NRC;
                end
            end
            S_NRC: begin
                if (bus.bit_en && cnt == NRC_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign active = (state == S_SEND) || (state == S_WAIT) ||
                    (state == S_RECV) || (state == S_NRC);

    // One shared bit counter: restarts on every state change; RECV starts at 1
    // because the start bit that triggered the transition is already captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (state_next != state) begin
            cnt <= (state_next == S_RECV) ? 16'd1 : 16'd0;
        end else if (active && bus.bit_en) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= 40'd0;
            rtype     <= 2'd0;
            crc       <= 7'd0;
            cmd_out_r <= 1'b1;
            cmd_oe_r  <= 1'b0;
            resp_r    <= 48'd0;
            crc_err_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        shift_reg <= {2'b01, bus.cmd_index, bus.cmd_arg};
                        rtype     <= bus.resp_type;
                        crc       <= 7'd0;
                        crc_err_r <= 1'b0;
                        timeout_r <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (bus.bit_en) begin
                        cmd_oe_r <= 1'b1;
                        if (cnt < CRC_BITS) begin
                            cmd_out_r <= shift_reg[39];
                            shift_reg <= {shift_reg[38:0], 1'b0};
                            crc       <= crc7_next(crc, shift_reg[39]);
                        end else if (cnt < FRAME_LAST) begin
                            // CRC bits leave MSB first by shifting the register itself.
                            cmd_out_r <= crc[6];
                            crc       <= {crc[5:0], 1'b0};
                        end else begin
                            cmd_out_r <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.bit_en) begin
                        cmd_oe_r  <= 1'b0;
                        cmd_out_r <= 1'b1;
                        if (!bus.cmd_in) begin
                            resp_r <= 48'd0;
                            crc    <= 7'd0;
                        end else if (cnt == TO_LAST) begin
                            timeout_r <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (bus.bit_en) begin
                        cmd_oe_r  <= 1'b0;
                        cmd_out_r <= 1'b1;
                        resp_r    <= {resp_r[46:0], bus.cmd_in};
                        if (cnt < CRC_BITS) begin
                            crc <= crc7_next(crc, bus.cmd_in);
                        end
                        // On the end bit, resp_r[6:0] already holds the received CRC field.
                        if (cnt == FRAME_LAST) begin
                            if (rtype == 2'd2) begin
                                crc_err_r <= ~bus.cmd_in;
                            end else begin
                                crc_err_r <= (resp_r[6:0] != crc) | ~bus.cmd_in;
                            end
                        end
                    end
                end
                S_NRC: begin
                    if (bus.bit_en) begin
                        cmd_oe_r  <= 1'b0;
                        cmd_out_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = active;
    assign bus.done    = (state == S_DONE);
    assign bus.cmd_out = cmd_out_r;
    assign bus.cmd_oe  = cmd_oe_r;
    assign bus.resp    = resp_r;
    assign bus.crc_err = crc_err_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Scoreboard bench for sd_cmd_ctrl: a driver issues commands and plays the card,
// a negedge monitor captures the CMD frame and checks each done against a queue.
module tb_sd_cmd_ctrl;

    localparam int TO_BITS = 64;
    localparam int NRC     = 8;

    typedef struct {
        logic [47:0] frame;
        logic [47:0] resp;
        logic        crc_err;
        logic        timeout;
        int          strobes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sd_cmd_ctrl_if bus();

    sd_cmd_ctrl #(
        .TIMEOUT_BITS(TO_BITS),
        .NRC_BITS    (NRC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          pass_cnt   = 0;
    int          total_cnt  = 0;
    int          done_cnt   = 0;
    int          period     = 4;
    int          phase      = 0;
    exp_t        sb[$];
    logic [47:0] model_resp = 48'd0;

    // SD-clock strobe source; it changes shortly after each edge so every
    // sampling point sees a settled value.
    always @(posedge clk) begin
        #2;
        phase = phase + 1;
        bus.bit_en = ((phase % period) == 0);
    end

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc_model(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) begin
                r[i-:8] = r[i-:8] ^ 8'h89;
            end
        end
        return r[6:0];
    endfunction

    task automatic wait_strobe();
        do begin
            @(posedge clk);
        end while (bus.bit_en !== 1'b1);
        #1;
    endtask

    logic        pend_strobe = 1'b0;
    logic [47:0] cap_frame   = 48'd0;
    int          oe_cnt      = 0;
    int          strobe_cnt  = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            pend_strobe = 1'b0;
            cap_frame   = 48'd0;
            oe_cnt      = 0;
            strobe_cnt  = 0;
        end else begin
            if (pend_strobe && bus.cmd_oe) begin
                cap_frame = {cap_frame[46:0], bus.cmd_out};
                oe_cnt++;
            end
            pend_strobe = bus.bit_en;
            if (bus.bit_en && bus.busy) begin
                strobe_cnt++;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pending transaction");
                end else begin
                    e = sb.pop_front();
                    checkOutput("frame", cap_frame, e.frame);
                    checkOutput("oe_strobes", 48'(oe_cnt), 48'd48);
                    checkOutput("busy_strobes", 48'(strobe_cnt), 48'(e.strobes));
                    checkOutput("resp", bus.resp, e.resp);
                    checkOutput("crc_err", 48'(bus.crc_err), 48'(e.crc_err));
                    checkOutput("timeout", 48'(bus.timeout), 48'(e.timeout));
                    checkOutput("busy_at_done", 48'(bus.busy), 48'd0);
                end
                done_cnt++;
                cap_frame  = 48'd0;
                oe_cnt     = 0;
                strobe_cnt = 0;
            end
        end
    end

    task automatic applyStimulus(
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [1:0]  rtype,
        input int          per,
        input bit          respond,
        input int          gap,
        input logic [47:0] card,
        input bit          use_lit,
        input logic [47:0] lit,
        input bit          poke
    );
        exp_t        e;
        int          d0;
        int          k;
        logic [39:0] hdr;
        hdr       = {2'b01, idx, arg};
        e.frame   = use_lit ? lit : {hdr, crc_model(hdr), 1'b1};
        e.timeout = (rtype != 2'd0) && !respond;
        if (rtype == 2'd0) begin
            e.crc_err = 1'b0;
            e.resp    = model_resp;
            e.strobes = 48 + NRC;
        end else if (!respond) begin
            e.crc_err = 1'b0;
            e.resp    = model_resp;
            e.strobes = 48 + TO_BITS + NRC;
        end else begin
            e.resp    = card;
            e.crc_err = (rtype == 2'd2) ? !card[0]
                                        : ((card[7:1] != crc_model(card[47:8])) || !card[0]);
            e.strobes = 48 + gap + 48 + NRC;
        end
        model_resp = e.resp;
        sb.push_back(e);
        period = per;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_type = rtype;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (poke && i == 10) begin
                bus.start     = 1'b1;
                bus.cmd_index = ~idx;
            end
            wait_strobe();
            if (poke && i == 10) begin
                bus.start     = 1'b0;
                bus.cmd_index = idx;
            end
        end
        if (rtype != 2'd0 && respond) begin
            repeat (gap) wait_strobe();
            for (int b = 47; b >= 0; b--) begin
                bus.cmd_in = card[b];
                wait_strobe();
            end
            bus.cmd_in = 1'b1;
        end
        k = 0;
        while (done_cnt == d0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == d0) begin
            total_cnt++;
            $display("[TB] FAIL done_wait: got no done within 4000 clks expected one done pulse");
        end
    endtask

    initial begin
        logic [5:0]  r_idx;
        logic [31:0] r_arg;
        logic [1:0]  r_type;
        logic [39:0] r_hdr;
        logic [6:0]  r_crc;
        logic        r_end;
        int          d0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cmd_in    = 1'b1;
        bus.cmd_index = 6'd0;
        bus.cmd_arg   = 32'd0;
        bus.resp_type = 2'd0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_cmd_out", 48'(bus.cmd_out), 48'd1);
        checkOutput("rst_cmd_oe", 48'(bus.cmd_oe), 48'd0);
        checkOutput("rst_busy", 48'(bus.busy), 48'd0);
        checkOutput("rst_done", 48'(bus.done), 48'd0);
        checkOutput("rst_resp", bus.resp, 48'd0);
        checkOutput("rst_flags", {46'd0, bus.crc_err, bus.timeout}, 48'd0);
        rst = 1'b0;

        applyStimulus(6'd0, 32'h0, 2'd0, 4, 1'b0, 0, 48'd0, 1'b1, 48'h400000000095, 1'b0);
        applyStimulus(6'd8, 32'h000001AA, 2'd1, 2, 1'b1, 2, 48'h08000001AA13, 1'b1, 48'h48000001AA87, 1'b0);
        applyStimulus(6'd8, 32'h000001AA, 2'd1, 3, 1'b1, 2, 48'h08000001AA11, 1'b1, 48'h48000001AA87, 1'b0);
        applyStimulus(6'd17, 32'h0, 2'd1, 2, 1'b0, 0, 48'd0, 1'b1, 48'h510000000055, 1'b1);
        applyStimulus(6'd41, 32'h40FF8000, 2'd2, 1, 1'b1, 3, 48'h3F80FF8000FF, 1'b0, 48'd0, 1'b0);

        // Abort in the middle of the command frame.
        period = 2;
        @(posedge clk);
        #1;
        bus.cmd_index = 6'd24;
        bus.cmd_arg   = 32'h12345678;
        bus.resp_type = 2'd1;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (21) wait_strobe();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_cmd_oe", 48'(bus.cmd_oe), 48'd0);
        checkOutput("abort_cmd_out", 48'(bus.cmd_out), 48'd1);
        checkOutput("abort_busy", 48'(bus.busy), 48'd0);
        checkOutput("abort_done", 48'(bus.done), 48'd0);
        checkOutput("abort_resp", bus.resp, 48'd0);
        model_resp = 48'd0;
        d0 = done_cnt;
        repeat (300) @(posedge clk);
        checkOutput("no_done_after_abort", 48'(done_cnt), 48'(d0));

        for (int t = 0; t < 20; t++) begin
            r_idx  = 6'($urandom_range(0, 63));
            r_arg  = $urandom;
            r_type = 2'($urandom_range(0, 3));
            r_hdr  = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
            r_crc  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : crc_model(r_hdr);
            r_end  = ($urandom_range(0, 5) != 0);
            applyStimulus(r_idx, r_arg, r_type, int'($urandom_range(1, 4)),
                          ($urandom_range(0, 4) != 0), int'($urandom_range(0, 20)),
                          {r_hdr, r_crc, r_end}, 1'b0, 48'd0, 1'b0);
        end

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sd_cmd_ctrl.md
Name: sd_cmd_ctrl

Overview:
- Sequences one SD-card command transaction on the CMD line.
- Builds the 48-bit frame: start 0, transmit 1, 6-bit index, 32-bit argument, CRC7, end 1.
- Generates CRC7 serially (x^7+x^3+1) while shifting the frame out, then optionally captures and CRC-checks a 48-bit response.
- Sits between the card-init/read FSM and the CMD pad; all bit timing comes from an external SD-clock strobe.

Parameters:
- TIMEOUT_BITS, 64, max strobes waiting for the response start bit (NCR limit)
- NRC_BITS, 8, idle strobes appended after a transaction before done

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  one-cycle strobe, one per SD clock period; every bit action happens only on cycles with bit_en=1
- start  input  1  request; accepted only in IDLE
- cmd_index  input  6  command index, sampled at accept
- cmd_arg  input  32  argument, sampled at accept
- resp_type  input  2  sampled at accept: 0 none, 1 48-bit with CRC check, 2 48-bit no CRC check (R3), 3 treated as 1
- cmd_in  input  1  CMD line from pad
- cmd_out  output  1  CMD drive value
- cmd_oe  output  1  pad output enable
- busy  output  1  high from accept until done
- done  output  1  one-cycle pulse at end of transaction
- resp  output  48  captured response, MSB = first bit received
- crc_err  output  1  valid with done
- timeout  output  1  valid with done

Behaviour:
- Reset: state IDLE; cmd_out=1, cmd_oe=0, busy=0, done=0, resp=0, crc_err=0, timeout=0, CRC reg=0, counters=0. Reset mid-transaction aborts immediately with no done pulse.
- IDLE: start=1 latches inputs into a 40-bit shift reg {2'b01, index, arg}; busy=1 next cycle; clears crc_err/timeout; CRC reg=0; goes to SEND. A start while busy is ignored.
- SEND, 48 strobes, MSB first. cmd_oe=1.
  - Bits 0..39 drive the shift reg MSB. Each such strobe updates CRC: fb = bit ^ c[6]; c = {c[5:3], c[2]^fb, c[1:0], fb}.
  - Bits 40..46 drive c[6..0]; bit 47 drives 1.
  - cmd_out changes only on bit_en cycles.
- After bit 47 (the end bit):
  - resp_type 0 -> NRC.
  - Otherwise -> WAIT: cmd_oe=0, cmd_out=1.
- WAIT:
  - Each strobe samples cmd_in; 0 = start bit -> RECV, with resp[47]=0 and a received-bit count of 1.
  - No start bit within TIMEOUT_BITS strobes -> timeout=1, go to NRC.
- RECV:
  - Shift cmd_in into resp on each strobe until 48 bits are captured.
  - CRC reg is reset at the start bit and updated over the 40 bits from the start bit through bit 8.
  - For resp_type 1 or 3: crc_err=1 if resp[7:1] != computed CRC or resp[0] != 1.
  - For resp_type 2: only the end bit is checked.
  - Then go to NRC.
- NRC: cmd_oe=0, cmd_out=1 for NRC_BITS strobes -> DONE.
- DONE: done=1 for one clk, busy=0 on the same cycle, return to IDLE. resp, crc_err and timeout hold until the next accept.
- bit_en held low stalls every state indefinitely. Transitions happen only on strobes, except accept and DONE, which are clk-synchronous.
- Latency: resp_type 0 completes in 48+NRC_BITS strobes plus 2 clks.

Test Plan:
- CMD0, arg 0, resp_type 0, bit_en every 4 clks -> serial frame 40 00 00 00 00 95; cmd_oe high for exactly 48 strobes; done after 56 strobes; crc_err=0, timeout=0.
- CMD8, arg 0x000001AA, resp_type 1; card returns 08 00 00 01 AA 13 after 2 idle strobes -> frame 48 00 00 01 AA 87; resp=0x08000001AA13; crc_err=0.
- Same as above, but the card returns ...AA 11 (bad CRC) -> crc_err=1, resp=0x08000001AA11, done pulsed.
- CMD17, arg 0, resp_type 1; cmd_in held 1 -> frame 51 00 00 00 00 55; timeout=1 after 64 wait strobes; done follows after 8 NRC strobes.
- ACMD41, arg 0x40FF8000, resp_type 2; response 3F 80 FF 80 00 FF -> crc_err=0 despite the 7F CRC field.
- Assert rst during SEND bit 20 -> next cycle cmd_oe=0, cmd_out=1, busy=0, no done. A start pulsed while busy is ignored.
